// File: rtl/cpu_cache_tag_fill.sv
// Write side of the cache tag store.
//
// Sweeps every tag entry to invalid after reset and on request, and on a
// cacheable read miss remembers the page number and shadow bit of the access
// so they can be written as the new tag once memory returns the line.
// FMISS tells the hit comparator to report a miss while the tag store is
// being rewritten.
//
// Handshake contract: a REQ_RD strobe is accepted only in a cycle where BUSY
// is low (IDLE) with CON_n low and CACHEABLE high; otherwise it is dropped.
// MEM_ACK and CLR_REQ are single-cycle pulses with no back-pressure; a
// CLR_REQ that arrives while a fill is in flight is remembered and served on
// the first IDLE cycle, while one that arrives during a sweep is absorbed.
//
// All outputs are decoded from registered state only. rstHeld is a
// registered copy of sysrst so that the cycles following a reset edge show
// the quiet reset values, and the first sweep write (address 0) appears in
// the cycle after reset is released.
module cpu_cache_tag_fill #(
   parameter int INDEX_W = 10,
   parameter int TAG_W   = 14
) (
   input  logic               sysclk,
   input  logic               sysrst,
   input  logic               CON_n,
   input  logic               REQ_RD,
   input  logic               CACHEABLE,
   input  logic [INDEX_W-1:0] INDEX,
   input  logic [TAG_W-1:0]   PPN_23_10,
   input  logic               LSHADOW,
   input  logic               HIT0_n,
   input  logic               HIT1_n,
   input  logic               MEM_ACK,
   input  logic               CLR_REQ,
   output logic               TAG_WE_n,
   output logic [INDEX_W-1:0] TAG_ADDR,
   output logic [TAG_W-1:0]   TAG_DATA,
   output logic               TAG_SHADOW,
   output logic               TAG_VALID,
   output logic               FMISS,
   output logic               BUSY,
   output logic [2:0]         dbgState
);

   typedef enum logic [2:0] {
      CLEAR    = 3'd0,
      IDLE     = 3'd1,
      LOOKUP   = 3'd2,
      WAIT_MEM = 3'd3,
      WRITE    = 3'd4
   } stateT;

   localparam logic [INDEX_W-1:0] LAST_INDEX = '1;

   stateT              state;
   stateT              stateNext;
   logic [INDEX_W-1:0] clrCnt;
   logic [INDEX_W-1:0] clrCntNext;
   logic               pendClr;
   logic               pendClrNext;
   logic               rstHeld;
   logic               latchEn;
   logic [INDEX_W-1:0] idxQ;
   logic [TAG_W-1:0]   ppnQ;
   logic               shadowQ;
   logic               cacheReq;
   logic               tagHit;

   // An access qualifies for a fill only when the cache is on and the
   // access is cacheable; a hit needs both halves of the compare to match.
   assign cacheReq = REQ_RD && !CON_n && CACHEABLE;
   assign tagHit   = !(HIT0_n || HIT1_n);

   // State register, sweep counter, pending-clear flag and reset shadow.
   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         state   <= CLEAR;
         clrCnt  <= '0;
         pendClr <= 1'b0;
         rstHeld <= 1'b1;
      end else begin
         state   <= stateNext;
         clrCnt  <= clrCntNext;
         pendClr <= pendClrNext;
         rstHeld <= 1'b0;
      end
   end

   // Capture the missing access so later input changes cannot corrupt the tag.
   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         idxQ    <= '0;
         ppnQ    <= '0;
         shadowQ <= 1'b0;
      end else if (latchEn) begin
         idxQ    <= INDEX;
         ppnQ    <= PPN_23_10;
         shadowQ <= LSHADOW;
      end
   end

   // Next-state logic: sweep, idle dispatch, lookup, memory wait, tag write.
   always_comb begin
      stateNext   = state;
      clrCntNext  = clrCnt;
      pendClrNext = pendClr;
      latchEn     = 1'b0;
      case (state)
         CLEAR: begin
            // The cycle right after a reset edge writes nothing, so the
            // counter holds until the sweep is actually emitting writes.
            if (!rstHeld) begin
               clrCntNext = clrCnt + 1'b1;
               if (clrCnt == LAST_INDEX) begin
                  stateNext = IDLE;
               end
            end
         end
         IDLE: begin
            if (CLR_REQ || pendClr) begin
               // A clear wins over a same-cycle read, which is dropped.
               stateNext   = CLEAR;
               clrCntNext  = '0;
               pendClrNext = 1'b0;
            end else if (cacheReq) begin
               latchEn   = 1'b1;
               stateNext = LOOKUP;
            end
         end
         LOOKUP: begin
            if (CLR_REQ) begin
               pendClrNext = 1'b1;
            end
            if (tagHit) begin
               stateNext = IDLE;
            end else begin
               stateNext = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (CLR_REQ) begin
               pendClrNext = 1'b1;
            end
            // Turning the cache off abandons the fill even if data arrives.
            if (CON_n) begin
               stateNext = IDLE;
            end else if (MEM_ACK) begin
               stateNext = WRITE;
            end
         end
         WRITE: begin
            if (CLR_REQ) begin
               pendClrNext = 1'b1;
            end
            stateNext = IDLE;
         end
         default: begin
            stateNext  = CLEAR;
            clrCntNext = '0;
         end
      endcase
   end

   // Output decode from the registered state, sweep counter and fill latch.
   always_comb begin
      TAG_WE_n   = 1'b1;
      TAG_ADDR   = '0;
      TAG_DATA   = '0;
      TAG_SHADOW = 1'b0;
      TAG_VALID  = 1'b0;
      FMISS      = 1'b0;
      BUSY       = 1'b1;
      if (rstHeld) begin
         FMISS = 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               TAG_WE_n = 1'b0;
               TAG_ADDR = clrCnt;
               FMISS    = 1'b1;
            end
            IDLE: begin
               BUSY = 1'b0;
            end
            WRITE: begin
               TAG_WE_n   = 1'b0;
               TAG_ADDR   = idxQ;
               TAG_DATA   = ppnQ;
               TAG_SHADOW = shadowQ;
               TAG_VALID  = 1'b1;
               FMISS      = 1'b1;
            end
            default: begin
               BUSY = 1'b1;
            end
         endcase
      end
   end

   assign dbgState = state;

endmodule
